// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// mem_bus_pkg
// Shared decode constants for the byte-wide CPU memory bus.
// Revision: 1.0
// ============================================================================
package mem_bus_pkg;

    localparam logic [1:0] IO_SEL      = 2'b11;
    localparam logic [2:0] IO_DATA_OFS = 3'd0;
    localparam logic [2:0] IO_STAT_OFS = 3'd4;
    localparam logic       BUS_READ    = 1'b0;
    localparam logic       BUS_WRITE   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/io_fifo.sv
`default_nettype none
// ============================================================================
// io_fifo
// Synchronous FIFO; push while full and pop while empty are ignored.
// Revision: 1.0
// ============================================================================
module io_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem_q [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            count_q <= count_d;
        end
    end

    // Storage is not reset; a write landing during reset is orphaned by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// mem_io_responder
// Byte RAM plus I/O window (TX FIFO, optional RX FIFO under IO_RX_EN).
// Revision: 1.0
// ============================================================================
module mem_io_responder
    import mem_bus_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready,
    input  logic [7:0]  io_rx_data,
    input  logic        io_rx_valid,
    output logic        io_rx_ready
);

    localparam int CW = FIFO_DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] CNT_ONE       = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [CW-1:0] TX_FULL_LEVEL =
        {1'b1, {FIFO_DEPTH_LOG2{1'b0}}} - {{(FIFO_DEPTH_LOG2-1){1'b0}}, 2'b10};

    logic       is_io, io_wr, io_rd, ram_wr, ram_rd;
    logic       data_wr, data_rd, stat_rd;
    logic [2:0] ofs;

    assign is_io   = (mem_a[17:16] == IO_SEL);
    assign ofs     = mem_a[2:0];
    assign io_wr   = is_io && (mem_wr == BUS_WRITE);
    assign io_rd   = is_io && (mem_wr == BUS_READ);
    assign ram_wr  = !is_io && (mem_wr == BUS_WRITE);
    assign ram_rd  = !is_io && (mem_wr == BUS_READ);
    assign data_wr = io_wr && (ofs == IO_DATA_OFS);
    assign data_rd = io_rd && (ofs == IO_DATA_OFS);
    assign stat_rd = io_rd && (ofs == IO_STAT_OFS);

    logic [7:0] ram [1 << RAM_ADDR_WIDTH];
    logic [7:0] ram_rdata_q;

    always_ff @(posedge clk) begin
        if (ram_wr) ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_dout;
        if (ram_rd) ram_rdata_q <= ram[mem_a[RAM_ADDR_WIDTH-1:0]];
    end

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [CW-1:0] tx_count, tx_count_d;

    assign io_tx_valid = !tx_empty;
    assign tx_push     = data_wr && !tx_full;
    assign tx_pop      = io_tx_valid && io_tx_ready;

    io_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2), .WIDTH(8)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (mem_dout),
        .rdata_o (io_tx_data),
        .count_o (tx_count),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    always_comb begin
        tx_count_d = tx_count;
        if (tx_push && !tx_pop) begin
            tx_count_d = tx_count + CNT_ONE;
        end else if (tx_pop && !tx_push) begin
            tx_count_d = tx_count - CNT_ONE;
        end
    end

    logic       rx_nonempty, rx_first;
    logic [7:0] rx_head;

`ifdef IO_RX_EN
    logic          rx_full, rx_empty, rx_push, rx_pop, rx_rd_q;
    logic [CW-1:0] rx_count;
    logic          unused_rx;

    assign rx_push     = io_rx_valid && !rx_full;
    assign io_rx_ready = !rx_full;
    assign rx_nonempty = !rx_empty;
    // The controller holds the address across a multi-cycle read; pop only once.
    assign rx_first    = data_rd && !rx_rd_q;
    assign rx_pop      = rx_first && rx_nonempty;
    assign unused_rx   = &{1'b0, rx_count};

    io_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2), .WIDTH(8)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i (io_rx_data),
        .rdata_o (rx_head),
        .count_o (rx_count),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_rd_q <= 1'b0;
        else     rx_rd_q <= data_rd;
    end
`else
    logic unused_rx;

    assign io_rx_ready = 1'b0;
    assign rx_nonempty = 1'b0;
    assign rx_head     = 8'h00;
    assign rx_first    = data_rd;
    assign unused_rx   = &{1'b0, io_rx_data, io_rx_valid};
`endif

    logic       sel_ram_q, sel_ram_d;
    logic [7:0] io_rdata_q, io_rdata_d;
    logic       tx_overflow_q, tx_overflow_d;
    logic       buffer_full_q;
    logic       unused_addr;

    assign unused_addr = &{1'b0, mem_a};

    always_comb begin
        sel_ram_d     = sel_ram_q;
        io_rdata_d    = io_rdata_q;
        tx_overflow_d = tx_overflow_q;
        if (ram_rd) begin
            sel_ram_d = 1'b1;
        end else if (io_rd) begin
            sel_ram_d = 1'b0;
            if (data_rd) begin
                if (rx_first) io_rdata_d = rx_nonempty ? rx_head : 8'h00;
            end else if (stat_rd) begin
                io_rdata_d    = {5'b0, tx_overflow_q, buffer_full_q, rx_nonempty};
                tx_overflow_d = 1'b0;
            end else begin
                io_rdata_d = 8'h00;
            end
        end
        if (data_wr && tx_full) tx_overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_ram_q     <= 1'b0;
            io_rdata_q    <= 8'h00;
            tx_overflow_q <= 1'b0;
            buffer_full_q <= 1'b0;
        end else begin
            sel_ram_q     <= sel_ram_d;
            io_rdata_q    <= io_rdata_d;
            tx_overflow_q <= tx_overflow_d;
            buffer_full_q <= (tx_count_d >= TX_FULL_LEVEL);
        end
    end

    // The RAM read register is unreset, so reset forces the I/O path onto mem_din.
    assign mem_din        = sel_ram_q ? ram_rdata_q : io_rdata_q;
    assign io_buffer_full = buffer_full_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_io_responder
// Directed checks of RAM, TX FIFO back-pressure/drain, RX pop and async reset.
// Revision: 1.0
// ============================================================================
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_a = 32'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_dout = 8'h0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready = 1'b0;
    logic [7:0]  io_rx_data = 8'h0;
    logic        io_rx_valid = 1'b0;
    logic        io_rx_ready;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef IO_RX_EN
    localparam logic EXP_RX_READY = 1'b1;
`else
    localparam logic EXP_RX_READY = 1'b0;
`endif
    localparam logic [31:0] IDLE_A = 32'h0003_0002;

    mem_io_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .io_tx_data     (io_tx_data),
        .io_tx_valid    (io_tx_valid),
        .io_tx_ready    (io_tx_ready),
        .io_rx_data     (io_rx_data),
        .io_rx_valid    (io_rx_valid),
        .io_rx_ready    (io_rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] d);
        mem_a    = a;
        mem_wr   = wr;
        mem_dout = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic        chk_din;
        logic [7:0]  din;
        logic        full;
        logic        valid;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [7:0] dq [3];
        dq[0] = 8'h11; dq[1] = 8'h22; dq[2] = 8'h33;

        vt[0] = '{32'h0000_0100, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1] = '{32'h0000_0101, 1'b1, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[2] = '{32'h0000_0102, 1'b1, 8'h56, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[3] = '{32'h0000_0103, 1'b1, 8'h78, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[4] = '{32'h0000_0103, 1'b0, 8'h00, 1'b1, 8'h78, 1'b0, 1'b0};
        vt[5] = '{32'h0000_0100, 1'b0, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0};
        vt[6] = '{32'h0003_0004, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[7] = '{32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        vt[8] = '{32'h0003_0001, 1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[9] = '{32'h0003_0002, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};

        // Reset state
        #12;
        check("reset mem_din", 32'(mem_din), 32'h00);
        check("reset io_buffer_full", 32'(io_buffer_full), 32'h0);
        check("reset io_tx_valid", 32'(io_tx_valid), 32'h0);
        check("reset io_rx_ready", 32'(io_rx_ready), 32'(EXP_RX_READY));
        @(negedge clk);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            cycle(vt[i].a, vt[i].wr, vt[i].dout);
            if (vt[i].chk_din) check($sformatf("vec%0d mem_din", i), 32'(mem_din), 32'(vt[i].din));
            check($sformatf("vec%0d io_buffer_full", i), 32'(io_buffer_full), 32'(vt[i].full));
            check($sformatf("vec%0d io_tx_valid", i), 32'(io_tx_valid), 32'(vt[i].valid));
        end

        // TX back-pressure: full after the 14th queued byte
        for (int k = 1; k <= 16; k++) begin
            cycle(32'h0003_0000, 1'b1, 8'(8'hA0 + k - 1));
            check($sformatf("bp write%0d io_buffer_full", k), 32'(io_buffer_full), 32'(k >= 14));
        end
        check("bp head data", 32'(io_tx_data), 32'hA0);
        cycle(32'h0003_0004, 1'b0, 8'h00);
        check("status at 16 entries", 32'(mem_din), 32'h02);
        cycle(32'h0003_0000, 1'b1, 8'hFF);
        cycle(32'h0003_0004, 1'b0, 8'h00);
        check("status after overflow", 32'(mem_din), 32'h06);
        cycle(32'h0003_0004, 1'b0, 8'h00);
        check("status overflow cleared", 32'(mem_din), 32'h02);

        // Full falls once the count drops below DEPTH-2
        io_tx_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle(IDLE_A, 1'b0, 8'h00);
            check($sformatf("pop%0d io_buffer_full", k), 32'(io_buffer_full), 32'(k < 3));
        end
        io_tx_ready = 1'b0;
        check("head after 3 pops", 32'(io_tx_data), 32'hA3);

        // Async reset between edges
        cycle(32'h0000_0103, 1'b0, 8'h00);
        check("pre-reset mem_din", 32'(mem_din), 32'h78);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async rst io_tx_valid", 32'(io_tx_valid), 32'h0);
        check("async rst io_buffer_full", 32'(io_buffer_full), 32'h0);
        check("async rst mem_din", 32'(mem_din), 32'h00);
        mem_a = IDLE_A;
        @(negedge clk);
        rst = 1'b0;

        // TX drain in write order
        for (int k = 0; k < 3; k++) cycle(32'h0003_0000, 1'b1, dq[k]);
        mem_a  = IDLE_A;
        mem_wr = 1'b0;
        io_tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drain%0d io_tx_data", k), 32'(io_tx_data), 32'(dq[k]));
            check($sformatf("drain%0d io_tx_valid", k), 32'(io_tx_valid), 32'h1);
            cycle(IDLE_A, 1'b0, 8'h00);
        end
        io_tx_ready = 1'b0;
        check("drained io_tx_valid", 32'(io_tx_valid), 32'h0);
        check("drained io_buffer_full", 32'(io_buffer_full), 32'h0);

`ifdef IO_RX_EN
        // RX: held read pops once
        io_rx_valid = 1'b1;
        io_rx_data  = 8'h41;
        cycle(IDLE_A, 1'b0, 8'h00);
        io_rx_data  = 8'h42;
        cycle(IDLE_A, 1'b0, 8'h00);
        io_rx_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(32'h0003_0000, 1'b0, 8'h00);
            check($sformatf("rx held%0d mem_din", k), 32'(mem_din), 32'h41);
        end
        cycle(IDLE_A, 1'b0, 8'h00);
        cycle(32'h0003_0000, 1'b0, 8'h00);
        check("rx second read", 32'(mem_din), 32'h42);
        cycle(IDLE_A, 1'b0, 8'h00);
        cycle(32'h0003_0000, 1'b0, 8'h00);
        check("rx empty read", 32'(mem_din), 32'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the byte-wide CPU memory bus driven by the memory controller. It owns the main byte RAM and the memory-mapped I/O window at `mem_a[17:16] == 2'b11`. Reads return data one cycle after the address is presented. Writes to the I/O data port are buffered in a TX FIFO, and `io_buffer_full` back-pressures the controller. It sits between the controller and the board-level RAM and UART wrappers.

## Interface
Parameters:
- `RAM_ADDR_WIDTH`, default 17: byte RAM is 2^17 bytes, indexed by `mem_a[RAM_ADDR_WIDTH-1:0]`.
- `FIFO_DEPTH_LOG2`, default 4: depth of each I/O FIFO is 16 entries.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `mem_a` in 32: byte address from the controller.
- `mem_wr` in 1: 1 = write, 0 = read.
- `mem_dout` in 8: write byte from the controller.
- `mem_din` out 8: registered read byte to the controller.
- `io_buffer_full` out 1: registered TX-FIFO back-pressure.
- `io_tx_data` out 8: head of the TX FIFO.
- `io_tx_valid` out 1: TX FIFO is non-empty.
- `io_tx_ready` in 1: UART accepts the head byte.
- `io_rx_data` in 8: byte from the UART.
- `io_rx_valid` in 1: UART byte is valid, pushed when the RX FIFO is not full.
- `io_rx_ready` out 1: RX FIFO is not full.

## Operation
- Decode: when `mem_a[17:16] == 2'b11` the access goes to the I/O window; otherwise it goes to the RAM. I/O offset is `mem_a[2:0]`.
- RAM write (`mem_wr=1`): `ram[mem_a]` takes `mem_dout` at the clock edge.
- RAM read (`mem_wr=0`): `mem_din` takes `ram[mem_a]` at the clock edge. There is no write-forwarding, because the controller never reads and writes in the same cycle.
- I/O write to offset 0: push `mem_dout` into the TX FIFO. If the FIFO is full, drop the byte and set a sticky `tx_overflow` bit.
- I/O writes to other offsets are ignored.
- I/O read at offset 0: `mem_din` takes the RX head, or 0x00 if the RX FIFO is empty.
  - The RX FIFO pops only on the first cycle of that read, i.e. when the previous cycle was not an I/O read at offset 0.
  - This rule exists because the controller holds the I/O address for several cycles.
- I/O read at offset 4: `mem_din = {5'b0, tx_overflow, io_buffer_full, rx_nonempty}`. This read clears `tx_overflow`.
- Other I/O offsets read as 0x00.
- `io_buffer_full` rises when the TX count after the current cycle's push and pop is `>= DEPTH-2`. The two-entry margin covers writes already in flight at the controller.
- TX pops when `io_tx_valid && io_tx_ready`. Push and pop in the same cycle leave the count unchanged.

## Timing
- Reset values:
  - `mem_din=0`, `io_buffer_full=0`, `io_tx_valid=0`, `io_rx_ready=1`.
  - Both FIFOs are empty, `tx_overflow=0`, and the RX-read edge flag is 0.
  - RAM contents are not reset.
- Read latency is exactly 1 cycle: an address presented in cycle N gives valid `mem_din` in cycle N+1. Back-to-back reads are supported every cycle.
- `io_buffer_full` is registered, so it is updated one edge after the push or pop that changes the count.
- `io_tx_data` and `io_tx_valid` come directly from FIFO state.
- Reset asserted mid-access aborts the access. A FIFO push or pop in that cycle is discarded.

## Configuration
- `IO_RX_EN` defined:
  - RX FIFO and the `io_rx_*` path are built.
  - Offset-0 reads return RX data, and status bit 0 reports RX non-empty.
- `IO_RX_EN` undefined:
  - No RX FIFO.
  - `io_rx_ready` is tied to 0, `io_rx_data` and `io_rx_valid` are ignored.
  - Offset-0 reads return 0x00, and status bit 0 is 0.

## Structure
- Shared package `mem_bus_pkg` holds:
  - `IO_SEL = 2'b11`
  - `IO_DATA_OFS = 3'd0`
  - `IO_STAT_OFS = 3'd4`
  - `BUS_READ = 1'b0`
  - `BUS_WRITE = 1'b1`
- One sub-module, `io_fifo`: a synchronous FIFO with parameterised depth and ports for push, pop, data, count, full and empty.
  - Instantiated once for TX.
  - Instantiated once for RX, only under `IO_RX_EN`.
- The RAM is an inferred array in the top level.

## Test plan
- RAM write then read: write 0x12, 0x34, 0x56, 0x78 to 0x100..0x103, then read 0x103 -> `mem_din` is 0x78 in the next cycle. Read 0x100 in the following cycle -> `mem_din` is 0x12.
- TX back-pressure:
  - Hold `io_tx_ready=0` and write 14 bytes to 0x30000 -> `io_buffer_full=1` one cycle after the 14th write.
  - Write 2 more bytes -> FIFO holds 16 entries, `tx_overflow=0`.
  - Write a 17th byte -> it is dropped and a status read returns 0x04 | 0x02.
- TX drain: with 3 bytes queued, pulse `io_tx_ready` for 3 cycles -> `io_tx_data` is presented in write order, then `io_tx_valid=0` and `io_buffer_full=0`.
- RX single pop (with `IO_RX_EN`):
  - Push 0x41, 0x42 via `io_rx_valid`.
  - Hold address 0x30000 for 3 read cycles -> `mem_din=0x41` and exactly one pop.
  - Next fresh read -> 0x42. Third fresh read -> 0x00.
- Async reset mid-stream: assert `rst` between edges while the TX FIFO is non-empty -> `io_tx_valid=0` and `io_buffer_full=0` immediately, and `mem_din=0`.
